// File: rtl/gate_seq_pkg.sv
// gate_seq_pkg: default vector widths and FSM state encoding shared by the gate vector sequencer
package gate_seq_pkg;
  localparam int N_IN_DEF = 22;
  localparam int N_OUT_DEF = 10;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VEC,
    ST_SETTLE,
    ST_CAPTURE,
    ST_REPORT,
    ST_FINISH
  } state_t;
endpackage

// File: rtl/gate_vector_sequencer_settle_timer.sv
// settle_timer: loadable down-counter (load/load_val, count enable); zero marks the cycle on which the count runs out
module settle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (count && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt <= W'(1);
endmodule

// File: rtl/gate_vector_sequencer.sv
// gate_vector_sequencer: applies vectors (vec_*) to a gate model (dut_in/dut_out), waits SETTLE cycles, reports masked compare (res_*), counts vectors/errors
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int N_OUT  = N_OUT_DEF,
  parameter int SETTLE = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [N_IN-1:0]  vec_in,
  input  logic [N_OUT-1:0] exp_in,
  input  logic [N_OUT-1:0] exp_mask,
  input  logic             vec_last,
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N_OUT-1:0] res_data,
  output logic             res_mismatch,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count
);
  state_t state_q, state_d;
  logic [N_OUT-1:0] exp_q, mask_q;
  logic last_q, xfer, capture, mis, t_zero;
  assign xfer = state_q == ST_WAIT_VEC && vec_valid;
  assign capture = state_q == ST_CAPTURE;
  assign mis = |((dut_out ^ exp_q) & mask_q);
  settle_timer #(.W(8)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (xfer),
    .load_val(8'(SETTLE)),
    .count   (state_q == ST_SETTLE),
    .zero    (t_zero)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = start ? ST_WAIT_VEC : ST_IDLE;
      ST_WAIT_VEC: state_d = vec_valid ? ST_SETTLE : ST_WAIT_VEC;
      ST_SETTLE:   state_d = t_zero ? ST_CAPTURE : ST_SETTLE;
      ST_CAPTURE:  state_d = ST_REPORT;
      ST_REPORT:   state_d = !res_ready ? ST_REPORT : last_q ? ST_FINISH : ST_WAIT_VEC;
      ST_FINISH:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    vec_ready = state_q == ST_WAIT_VEC;
    res_valid = state_q == ST_REPORT;
    done = state_q == ST_FINISH;
    busy = state_q != ST_IDLE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dut_in <= '0;
      exp_q <= '0;
      mask_q <= '0;
      last_q <= 1'b0;
      res_data <= '0;
      res_mismatch <= 1'b0;
      vec_count <= '0;
      err_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        vec_count <= '0;
        err_count <= '0;
      end
      if (xfer) begin
        dut_in <= vec_in;
        exp_q <= exp_in;
        mask_q <= exp_mask;
        last_q <= vec_last;
      end
      if (capture) begin
        res_data <= dut_out;
        res_mismatch <= mis;
        vec_count <= &vec_count ? vec_count : vec_count + 1'b1;
        err_count <= (mis && !(&err_count)) ? err_count + 1'b1 : err_count;
      end
    end
endmodule

// File: tb/tb_gate_vector_sequencer.sv
// tb_gate_vector_sequencer: directed tests for gate_vector_sequencer using a small combinational gate model
module tb_gate_vector_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, vec_valid = 1'b0, vec_last = 1'b0, res_ready = 1'b1;
  logic [21:0] vec_in = '0;
  logic [9:0] exp_in = '0, exp_mask = '0;
  logic vec_ready0, res_valid0, res_mismatch0, busy0, done0;
  logic vec_ready1, res_valid1, res_mismatch1, busy1, done1;
  logic [21:0] dut_in0, dut_in1;
  logic [9:0] dut_out0, dut_out1, res_data0, res_data1;
  logic [15:0] vec_count0, err_count0;
  logic [3:0] vec_count1, err_count1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  function automatic logic [9:0] model(input logic [21:0] v);
    return v[9:0] ^ v[19:10] ^ {v[21:20], 8'h5A};
  endfunction
  assign dut_out0 = model(dut_in0);
  assign dut_out1 = model(dut_in1);
  gate_vector_sequencer u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .vec_valid(vec_valid), .vec_ready(vec_ready0),
    .vec_in(vec_in), .exp_in(exp_in), .exp_mask(exp_mask), .vec_last(vec_last),
    .dut_in(dut_in0), .dut_out(dut_out0), .res_valid(res_valid0), .res_ready(res_ready),
    .res_data(res_data0), .res_mismatch(res_mismatch0), .busy(busy0), .done(done0),
    .vec_count(vec_count0), .err_count(err_count0)
  );
  gate_vector_sequencer #(.SETTLE(1), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .vec_valid(vec_valid), .vec_ready(vec_ready1),
    .vec_in(vec_in), .exp_in(exp_in), .exp_mask(exp_mask), .vec_last(vec_last),
    .dut_in(dut_in1), .dut_out(dut_out1), .res_valid(res_valid1), .res_ready(res_ready),
    .res_data(res_data1), .res_mismatch(res_mismatch1), .busy(busy1), .done(done1),
    .vec_count(vec_count1), .err_count(err_count1)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start(input bit sel);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask
  task automatic send(input bit sel, input logic [21:0] v, input logic [9:0] e, input logic [9:0] m,
                      input logic l, output logic [9:0] data, output logic mis);
    int n = 0;
    while (!(sel ? vec_ready1 : vec_ready0) && n < 50) begin tick(); n++; end
    checks++;
    if (!(sel ? vec_ready1 : vec_ready0)) begin
      errors++;
      $display("FAIL send_ready: vec_ready=0 after %0d cycles, required 1", n);
    end
    vec_in = v; exp_in = e; exp_mask = m; vec_last = l; vec_valid = 1'b1;
    tick();
    vec_valid = 1'b0;
    n = 0;
    while (!(sel ? res_valid1 : res_valid0) && n < 50) begin tick(); n++; end
    checks++;
    if (!(sel ? res_valid1 : res_valid0)) begin
      errors++;
      $display("FAIL send_result: res_valid=0 after %0d cycles, required 1", n);
    end
    data = sel ? res_data1 : res_data0;
    mis = sel ? res_mismatch1 : res_mismatch0;
  endtask
  task automatic count_done(input bit sel, input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      if (sel ? done1 : done0) pulses++;
      tick();
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy0, vec_ready0, res_valid0, done0, res_mismatch0} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000", {busy0, vec_ready0, res_valid0, done0, res_mismatch0});
    end
    checks++;
    if (dut_in0 !== '0 || res_data0 !== '0 || vec_count0 !== '0 || err_count0 !== '0) begin
      errors++;
      $display("FAIL reset_data: dut_in=%h res_data=%h vec=%0d err=%0d, required all 0", dut_in0, res_data0, vec_count0, err_count0);
    end
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_single();
    logic [21:0] v = 22'h2A5C31;
    int lat = 0, pulses;
    res_ready = 1'b1;
    pulse_start(1'b0);
    checks++;
    if (!busy0 || !vec_ready0) begin
      errors++;
      $display("FAIL single_wait: busy=%b vec_ready=%b, required 1 1", busy0, vec_ready0);
    end
    vec_in = v; exp_in = model(v); exp_mask = 10'h3FF; vec_last = 1'b1; vec_valid = 1'b1;
    tick();
    vec_valid = 1'b0;
    lat = 1;
    checks++;
    if (dut_in0 !== v) begin
      errors++;
      $display("FAIL single_dut_in: got %h, required %h", dut_in0, v);
    end
    while (!res_valid0 && lat < 40) begin tick(); lat++; end
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL single_latency: got %0d, required 6", lat);
    end
    checks++;
    if (res_mismatch0 !== 1'b0 || res_data0 !== model(v)) begin
      errors++;
      $display("FAIL single_result: mis=%b data=%h, required 0 %h", res_mismatch0, res_data0, model(v));
    end
    tick();
    count_done(1'b0, 8, pulses);
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL single_done: got %0d pulses, required 1", pulses);
    end
    checks++;
    if (vec_count0 !== 16'd1 || err_count0 !== 16'd0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL single_counts: vec=%0d err=%0d busy=%b, required 1 0 0", vec_count0, err_count0, busy0);
    end
  endtask
  task automatic test_multi();
    logic [21:0] vs [3] = '{22'h012345, 22'h3FFFFF, 22'h1C0A0B};
    logic [9:0] d;
    logic m;
    int pulses;
    res_ready = 1'b1;
    pulse_start(1'b0);
    for (int i = 0; i < 3; i++) begin
      send(1'b0, vs[i], (i == 1) ? model(vs[i]) ^ 10'h008 : model(vs[i]), 10'h3FF, i == 2, d, m);
      checks++;
      if (m !== (i == 1)) begin
        errors++;
        $display("FAIL multi_mis%0d: got %b, required %b", i, m, i == 1);
      end
    end
    count_done(1'b0, 6, pulses);
    checks++;
    if (vec_count0 !== 16'd3 || err_count0 !== 16'd1 || pulses !== 1) begin
      errors++;
      $display("FAIL multi_counts: vec=%0d err=%0d done=%0d, required 3 1 1", vec_count0, err_count0, pulses);
    end
  endtask
  task automatic test_mask();
    logic [21:0] v = 22'h3FFFFF;
    logic [9:0] d;
    logic m;
    int pulses;
    pulse_start(1'b0);
    send(1'b0, v, model(v) ^ 10'h008, 10'h3F7, 1'b1, d, m);
    checks++;
    if (m !== 1'b0 || d !== model(v)) begin
      errors++;
      $display("FAIL mask_result: mis=%b data=%h, required 0 %h", m, d, model(v));
    end
    count_done(1'b0, 6, pulses);
    checks++;
    if (err_count0 !== 16'd0 || vec_count0 !== 16'd1) begin
      errors++;
      $display("FAIL mask_counts: vec=%0d err=%0d, required 1 0", vec_count0, err_count0);
    end
  endtask
  task automatic test_stall();
    logic [21:0] v = 22'h155AA3;
    logic [9:0] d;
    logic m;
    int pulses, bad = 0;
    res_ready = 1'b0;
    pulse_start(1'b0);
    send(1'b0, v, model(v), 10'h3FF, 1'b1, d, m);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!res_valid0 || res_data0 !== model(v) || res_mismatch0 !== 1'b0 || vec_ready0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stall_hold: %0d unstable cycles, required 0 (valid=%b data=%h ready=%b)", bad, res_valid0, res_data0, vec_ready0);
    end
    res_ready = 1'b1;
    tick();
    count_done(1'b0, 6, pulses);
    checks++;
    if (pulses !== 1 || busy0) begin
      errors++;
      $display("FAIL stall_done: done=%0d busy=%b, required 1 0", pulses, busy0);
    end
  endtask
  task automatic test_back_to_back();
    logic [9:0] d;
    logic m;
    int pulses, rv = 0;
    res_ready = 1'b0;
    pulse_start(1'b0);
    send(1'b0, 22'h0000F0, model(22'h0000F0), 10'h3FF, 1'b0, d, m);
    pulse_start(1'b0);
    checks++;
    if (!res_valid0 || vec_count0 !== 16'd1) begin
      errors++;
      $display("FAIL start_ignored: res_valid=%b vec=%0d, required 1 1", res_valid0, vec_count0);
    end
    res_ready = 1'b1;
    tick();
    vec_in = 22'h0ABCDE; exp_in = model(22'h0ABCDE); exp_mask = 10'h3FF; vec_last = 1'b1; vec_valid = 1'b1;
    tick();
    vec_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (busy0 || vec_count0 !== '0 || err_count0 !== '0 || dut_in0 !== '0) begin
      errors++;
      $display("FAIL abort_reset: busy=%b vec=%0d err=%0d dut_in=%h, required 0 0 0 0", busy0, vec_count0, err_count0, dut_in0);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done0) pulses++;
      if (res_valid0) rv++;
      tick();
    end
    checks++;
    if (pulses !== 0 || rv !== 0 || busy0) begin
      errors++;
      $display("FAIL abort_quiet: done=%0d res_valid=%0d busy=%b, required 0 0 0", pulses, rv, busy0);
    end
  endtask
  task automatic test_saturate();
    logic [21:0] v;
    logic [9:0] d;
    logic m;
    int pulses;
    res_ready = 1'b1;
    pulse_start(1'b1);
    for (int i = 0; i < 20; i++) begin
      v = 22'(i * 37 + 5);
      send(1'b1, v, model(v) ^ 10'h001, 10'h3FF, i == 19, d, m);
      if (i == 13) begin
        checks++;
        if (err_count1 !== 4'd14 || vec_count1 !== 4'd14) begin
          errors++;
          $display("FAIL sat_mid: vec=%0d err=%0d, required 14 14", vec_count1, err_count1);
        end
      end
    end
    count_done(1'b1, 6, pulses);
    checks++;
    if (err_count1 !== 4'd15 || vec_count1 !== 4'd15 || pulses !== 1) begin
      errors++;
      $display("FAIL sat_final: vec=%0d err=%0d done=%0d, required 15 15 1", vec_count1, err_count1, pulses);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_multi();
    test_mask();
    test_stall();
    test_back_to_back();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gate_vector_sequencer.md
GATE_VECTOR_SEQUENCER -- requirements
Module: gate_vector_sequencer

Interface
REQ-001 The block SHALL have parameter N_IN, default 22, meaning the stimulus width driven into the gate model.
REQ-002 The block SHALL have parameter N_OUT, default 10, meaning the response width captured from the gate model.
REQ-003 The block SHALL have parameter SETTLE, default 4, meaning the number of wait cycles between applying a vector and capturing (legal range 1..255).
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning the width of the vector and error counters.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low.
REQ-006 The ports SHALL be, one per line (name, direction, width, meaning):
 clk  in  1  sole clock, rising edge.
 rst_n  in  1  synchronous active-low reset.
 start  in  1  one-cycle pulse that begins a run.
 vec_valid  in  1  stimulus vector offered.
 vec_ready  out  1  sequencer accepts the vector.
 vec_in  in  N_IN  stimulus vector.
 exp_in  in  N_OUT  expected response.
 exp_mask  in  N_OUT  compare mask (1 = compare bit).
 vec_last  in  1  this vector ends the run.
 dut_in  out  N_IN  drives gate model inputs N1..N22.
 dut_out  in  N_OUT  gate model outputs.
 res_valid  out  1  result available.
 res_ready  in  1  result consumer ready.
 res_data  out  N_OUT  captured dut_out.
 res_mismatch  out  1  masked compare failed.
 busy  out  1  run in progress.
 done  out  1  one-cycle end-of-run pulse.
 vec_count  out  CNT_W  vectors completed in the current or last run.
 err_count  out  CNT_W  mismatching vectors in the current or last run.

Function
REQ-007 The FSM SHALL have the states IDLE, WAIT_VEC, SETTLE, CAPTURE, REPORT and FINISH.
REQ-008 In IDLE, start=1 SHALL clear vec_count and err_count and move the FSM to WAIT_VEC on the next edge; start in any other state SHALL be ignored.
REQ-009 vec_ready SHALL be 1 only in WAIT_VEC; a transfer occurs when vec_valid and vec_ready are both 1.
REQ-010 On a transfer, the block SHALL register vec_in into dut_in on that edge, latch exp_in, exp_mask and vec_last, load the settle counter with SETTLE, and move to SETTLE.
REQ-011 SETTLE SHALL last exactly SETTLE cycles, then move to CAPTURE.
REQ-012 CAPTURE SHALL last one cycle and SHALL register res_data=dut_out and res_mismatch=|((dut_out^exp)&mask).
REQ-013 In CAPTURE, the block SHALL increment vec_count and, if res_mismatch is set, increment err_count; both counters SHALL saturate at all-ones without wrapping.
REQ-014 res_valid SHALL be 1 throughout REPORT, and res_data and res_mismatch SHALL be held stable until res_ready=1.
REQ-015 When res_ready=1 in REPORT, the FSM SHALL go to FINISH if the latched last flag is set, otherwise to WAIT_VEC.
REQ-016 The latency from vector transfer to res_valid SHALL be SETTLE+2 cycles.
REQ-017 FINISH SHALL assert done for exactly one cycle, then return to IDLE.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 dut_in SHALL hold the last applied vector in all states, including IDLE.
REQ-020 vec_count and err_count SHALL remain readable after done until the next start.

Reset
REQ-021 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE, and dut_in, res_data, vec_count and err_count SHALL be set to 0.
REQ-022 While rst_n=0 at a clock edge, res_valid, res_mismatch, vec_ready, busy and done SHALL be set to 0.
REQ-023 Reset asserted mid-run SHALL abort the run with no done pulse and no further result.

Structure
REQ-024 Package gate_seq_pkg SHALL hold the N_IN and N_OUT defaults and the FSM state enum.
REQ-025 The settle down-counter SHALL be a sub-module named settle_timer (load, count, zero flag).

Verification
REQ-026 The bench SHALL cover: SETTLE=4, one vector with vec_last=1 and matching exp, res_ready=1 -> res_valid 6 cycles after transfer, res_mismatch=0, done pulses once, vec_count=1, err_count=0.
REQ-027 The bench SHALL cover: three vectors with the second wrong in bit 3 and exp_mask=0x3FF -> err_count=1, vec_count=3.
REQ-028 The bench SHALL cover: the same wrong vector with exp_mask bit 3 cleared -> res_mismatch=0, err_count=0.
REQ-029 The bench SHALL cover: res_ready held low 5 cycles in REPORT -> res_valid and res_data stable, vec_ready=0 throughout.
REQ-030 The bench SHALL cover: err_count preset near all-ones with CNT_W=4 and 20 mismatches -> err_count saturates at 15.
REQ-031 The bench SHALL cover: rst_n=0 during SETTLE -> next cycle busy=0, counters 0, no done; start pulsed while busy -> no effect.
